// File: rtl/ftf_pkg.sv
// rtl/ftf_pkg.sv - shared state encoding and FP32 constants for fixed_to_float_seq
package ftf_pkg;
  typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} state_t;

  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam int          E_W          = 12;
endpackage

// File: rtl/fp32_pack.sv
// rtl/fp32_pack.sv - combinational pack of a normalised magnitude into FP32 with ovf/udf
// FTF_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise low bits are truncated.
module fp32_pack
  import ftf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             sign,
  input  logic [E_W-1:0]   pos,
  input  logic [E_W-1:0]   exp_in,
  input  logic [WIDTH-1:0] mag,
  output logic [31:0]      float,
  output logic             ovf,
  output logic             udf
);
  localparam logic [E_W-1:0] EXP_MAX = E_W'(FP32_EXP_MAX);

  // mag is normalised: frac[WIDTH+23] is the leading one, mantissa sits just below it
  logic [WIDTH+23:0] frac;
  logic [22:0]       mant;
  logic [E_W-1:0]    e;
  logic              unused_msb;

  assign frac       = {mag, 24'd0};
  assign unused_msb = frac[WIDTH+23];

`ifdef FTF_ROUND_NEAREST_EN
  logic guard;
  logic sticky;
  logic carry;

  assign guard = frac[WIDTH-1];
  if (WIDTH > 1) begin : g_sticky
    assign sticky = |frac[WIDTH-2:0];
  end

  always_comb begin
    mant  = frac[WIDTH+22:WIDTH];
    e     = pos + exp_in + E_W'(FP32_BIAS);
    carry = 1'b0;
    if (guard && (sticky || mant[0])) begin
      {carry, mant} = {1'b0, mant} + 24'd1;
    end
    if (carry) begin
      e = e + E_W'(1);
    end
  end
`else
  logic unused_low;

  assign unused_low = ^frac[WIDTH-1:0];

  always_comb begin
    mant = frac[WIDTH+22:WIDTH];
    e    = pos + exp_in + E_W'(FP32_BIAS);
  end
`endif

  always_comb begin
    ovf   = 1'b0;
    udf   = 1'b0;
    float = {sign, e[7:0], mant};
    if (!e[E_W-1] && e >= EXP_MAX) begin
      ovf   = 1'b1;
      float = {sign, FP32_POS_INF[30:0]};
    end else if (e[E_W-1] || e == '0) begin
      udf   = 1'b1;
      float = {sign, 31'd0};
    end
  end
endmodule

// File: rtl/fixed_to_float_seq.sv
// rtl/fixed_to_float_seq.sv - multi-cycle signed fixed-point to FP32 converter with valid/ready
// Rounding mode is chosen inside fp32_pack by FTF_ROUND_NEAREST_EN.
module fixed_to_float_seq
  import ftf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] fixed,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      float,
  output logic             ovf,
  output logic             udf
);
  localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] fixed_q;
  logic [WIDTH-1:0] mag;
  logic [E_W-1:0]   exp_q;
  logic [POS_W-1:0] pos;
  logic             sign;
  logic [31:0]      pack_float;
  logic             pack_ovf;
  logic             pack_udf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = ABS;
      ABS:  state_next = (fixed_q == '0) ? DONE : NORM;
      NORM: if (mag[WIDTH-1]) state_next = PACK;
      PACK: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fixed_q <= '0;
      mag     <= '0;
      exp_q   <= '0;
      pos     <= '0;
      sign    <= 1'b0;
      float   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          fixed_q <= fixed;
          exp_q   <= {{(E_W-EXP_W){exp_in[EXP_W-1]}}, exp_in};
        end
        ABS: begin
          // negating the most negative value wraps to 2^(WIDTH-1), still correct unsigned
          sign <= fixed_q[WIDTH-1];
          mag  <= fixed_q[WIDTH-1] ? (~fixed_q + 1'b1) : fixed_q;
          pos  <= POS_W'(WIDTH-1);
          if (fixed_q == '0) begin
            float <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
          end
        end
        NORM: if (!mag[WIDTH-1]) begin
          mag <= mag << 1;
          pos <= pos - 1'b1;
        end
        PACK: begin
          float <= pack_float;
          ovf   <= pack_ovf;
          udf   <= pack_udf;
        end
        default: ;
      endcase
    end
  end

  fp32_pack #(.WIDTH(WIDTH)) u_pack (
    .sign   (sign),
    .pos    ({{(E_W-POS_W){1'b0}}, pos}),
    .exp_in (exp_q),
    .mag    (mag),
    .float  (pack_float),
    .ovf    (pack_ovf),
    .udf    (pack_udf)
  );
endmodule
